// File: rtl/prog_encoder.sv
// Program loader/encoder: accepts instruction fields over valid/ready, packs them into
// the 16-bit control word and streams them sequentially into program memory.
module prog_encoder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    kind,
    input  logic [2:0]    alu_op,
    input  logic [1:0]    jcond,
    input  logic [3:0]    ra,
    input  logic [3:0]    rb,
    input  logic [3:0]    rd,
    input  logic [7:0]    imm,
    input  logic [9:0]    target,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wd,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    function automatic logic is_illegal(input logic [1:0] k, input logic [1:0] jc);
        logic bad;
        bad = 1'b0;
        case (k)
            2'b11:   bad = 1'b1;
            2'b10:   bad = (jc == 2'b11);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [15:0] encode(
        input logic [1:0] k,
        input logic [2:0] op,
        input logic [1:0] jc,
        input logic [3:0] s1,
        input logic [3:0] s2,
        input logic [3:0] d,
        input logic [7:0] im,
        input logic [9:0] tgt
    );
        logic [15:0] w;
        w = 16'h0000;
        case (k)
            2'b00:   w = {1'b1, op, s1, s2, d};
            2'b01:   w = {4'b0000, im, d};
            2'b10:   w = {4'b0001, jc, tgt};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_wd_q, mem_wd_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    logic          in_ready_s;
    logic          accept_s;
    logic [AW:0]   count_inc_s;

    assign in_ready_s  = (state_q == IDLE) && !clr;
    assign accept_s    = in_valid && in_ready_s;
    assign count_inc_s = count_q + (AW+1)'(1);

    // Next-state logic: accept/encode in IDLE, commit pointer in WRITE, clr overrides increment.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        full_d     = full_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    ptr_d   = {AW{1'b0}};
                    count_d = {(AW+1){1'b0}};
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = IDLE;
                end else if (accept_s) begin
                    if (is_illegal(kind, jcond)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ptr_q;
                        mem_wd_d   = encode(kind, alu_op, jcond, ra, rb, rd, imm, target);
                        state_d    = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (clr) begin
                    ptr_d   = {AW{1'b0}};
                    count_d = {(AW+1){1'b0}};
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                    count_d = count_inc_s;
                    if (count_inc_s == DEPTH_C) begin
                        full_d  = 1'b1;
                        state_d = FULL;
                    end else begin
                        full_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            FULL: begin
                if (clr) begin
                    ptr_d   = {AW{1'b0}};
                    count_d = {(AW+1){1'b0}};
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= {AW{1'b0}};
            count_q    <= {(AW+1){1'b0}};
            mem_we_q   <= 1'b0;
            mem_addr_q <= {AW{1'b0}};
            mem_wd_q   <= 16'h0000;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            full_q     <= full_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_s;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign count    = count_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_encoder.sv
// Scoreboard bench for prog_encoder: stimulus pushes expected writes, a negedge monitor
// pops and compares each mem_we pulse.
module tb_prog_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    kind = 2'b00;
    logic [2:0]    alu_op = 3'd0;
    logic [1:0]    jcond = 2'b00;
    logic [3:0]    ra = 4'd0;
    logic [3:0]    rb = 4'd0;
    logic [3:0]    rd = 4'd0;
    logic [7:0]    imm = 8'h00;
    logic [9:0]    target = 10'h000;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wd;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    prog_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .alu_op(alu_op), .jcond(jcond),
        .ra(ra), .rb(rb), .rd(rd), .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int exp_ptr = 0;
    logic [AW+15:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_wr++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr=%0h wd=%0h expected no write", mem_addr, mem_wd);
            end else begin
                logic [AW+15:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[AW+15:16]));
                chk("wr_data", 32'(mem_wd), 32'(e[15:0]));
            end
        end
    end

    task automatic set_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        kind = 2'b00; alu_op = op; ra = a; rb = b; rd = d;
    endtask

    task automatic set_li(input logic [7:0] im, input logic [3:0] d);
        kind = 2'b01; imm = im; rd = d; ra = 4'hF;
    endtask

    task automatic set_jmp(input logic [1:0] jc, input logic [9:0] tgt);
        kind = 2'b10; jcond = jc; target = tgt;
    endtask

    // Present current fields until accepted; legal ones enter the scoreboard.
    task automatic send(input logic legal, input logic [15:0] exp_wd);
        int t;
        t = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        if (in_ready && legal) begin
            sb.push_back({AW'(exp_ptr), exp_wd});
            exp_ptr++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic settle();
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    logic [15:0] b2b_wd[3] = '{16'h02A4, 16'h1955, 16'h17FF};
    logic [15:0] fill_wd[4] = '{16'h0100, 16'h0111, 16'h0122, 16'h0133};

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wd", 32'(mem_wd), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Single ALU instruction
        set_alu(3'd2, 4'd3, 4'd5, 4'd7);
        send(1'b1, 16'hA357);
        @(negedge clk);
        chk("t1_we_pulse", 32'(mem_we), 32'd1);
        chk("t1_ready_in_write", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        do_clr();

        // Back-to-back with in_valid held high
        n0 = n_wr;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_li(8'h2A, 4'd4);
                1: set_jmp(2'b10, 10'h155);
                default: set_jmp(2'b01, 10'h3FF);
            endcase
            sb.push_back({AW'(exp_ptr), b2b_wd[i]});
            exp_ptr++;
            @(negedge clk);
            chk("b2b_ready_hi", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            if (i == 2) in_valid = 1'b0;
            @(negedge clk);
            chk("b2b_ready_lo", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b2b_count", 32'(count), 32'd3);
        chk("b2b_pulses", 32'(n_wr - n0), 32'd3);
        @(posedge clk); #1;
        do_clr();

        // Illegal instructions leave the pointer alone and set err
        kind = 2'b11;
        send(1'b0, 16'h0000);
        @(negedge clk);
        chk("ill1_err", 32'(err), 32'd1);
        chk("ill1_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        set_jmp(2'b11, 10'h0AA);
        send(1'b0, 16'h0000);
        @(negedge clk);
        chk("ill2_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        set_jmp(2'b00, 10'h000);
        send(1'b1, 16'h1000);
        settle();
        chk("ill_err_sticky", 32'(err), 32'd1);
        chk("ill_count_after_j", 32'(count), 32'd1);
        @(posedge clk); #1;
        do_clr();
        @(negedge clk);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        @(posedge clk); #1;

        // Fill to DEPTH, then a fifth instruction is refused
        for (int i = 0; i < 4; i++) begin
            set_li(8'h10 + 8'(i), 4'(i));
            send(1'b1, fill_wd[i]);
        end
        settle();
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        set_li(8'h55, 4'd5);
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_refuse", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        do_clr();
        @(negedge clk);
        chk("full_clr_flag", 32'(full), 32'd0);
        chk("full_clr_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        set_alu(3'd7, 4'hF, 4'h0, 4'h9);
        send(1'b1, 16'hFF09);
        settle();
        chk("post_full_count", 32'(count), 32'd1);
        @(posedge clk); #1;

        // clr during WRITE at address 2
        set_jmp(2'b00, 10'h2AA);
        send(1'b1, 16'h12AA);
        set_alu(3'd0, 4'd0, 4'd0, 4'd0);
        send(1'b1, 16'h8000);
        clr = 1'b1;
        @(negedge clk);
        chk("clrw_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        chk("clrw_count", 32'(count), 32'd0);
        chk("clrw_we_off", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        set_li(8'hFF, 4'hF);
        send(1'b1, 16'h0FFF);
        settle();
        chk("clrw_count_after", 32'(count), 32'd1);
        @(posedge clk); #1;

        // reset during WRITE drops the commit and zeroes outputs
        kind = 2'b11;
        send(1'b0, 16'h0000);
        set_alu(3'd5, 4'd1, 4'd2, 4'd3);
        send(1'b1, 16'hD123);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_we", 32'(mem_we), 32'd0);
        chk("rstw_addr", 32'(mem_addr), 32'd0);
        chk("rstw_wd", 32'(mem_wd), 32'd0);
        chk("rstw_count", 32'(count), 32'd0);
        chk("rstw_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
        chk("rstw_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        set_jmp(2'b01, 10'h001);
        send(1'b1, 16'h1401);
        settle();
        chk("rstw_count_after", 32'(count), 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
